// File: rtl/usb_crc5_tx.sv
// usb_crc5_tx: bit-serial USB token/SOF CRC5 generator for the transmit path.
// Data bits pass straight through to the stuffer while the CRC5 (x^5+x^2+1)
// is accumulated. Then the five inverted CRC bits are driven, MSB of the
// register first, which is the same as crc_field[0] first.
module usb_crc5_tx #(
    parameter int DATA_BITS = 11
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       shift_en,
    input  logic       tx_bit_in,
    output logic       tx_bit_out,
    output logic       crc_active,
    output logic       busy,
    output logic       done,
    output logic [4:0] crc_field
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] CRC_INIT      = 5'b11111;
    localparam logic [4:0] CRC_POLY      = 5'b00101;
    localparam logic [3:0] CNT_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] CNT_CRC_LAST  = 4'd4;

    state_t     r_state;
    logic [4:0] r_crc;
    logic [3:0] r_cnt;
    logic [4:0] r_crc_field;
    logic       r_busy;
    logic       r_crc_active;
    logic       r_done;
    logic [4:0] w_next_crc;

    // One serial CRC5 update: feedback is the outgoing MSB xor the data bit.
    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
        logic fb;
        fb = crc[4] ^ din;
        return {crc[3:0], 1'b0} ^ (fb ? CRC_POLY : 5'b00000);
    endfunction

    // Reverse bit order so that field bit 0 is the first bit on the wire.
    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    assign w_next_crc = crc5_step(r_crc, tx_bit_in);

    // Control FSM with CRC register, bit counter and registered status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_crc        <= CRC_INIT;
            r_cnt        <= 4'd0;
            r_crc_field  <= 5'b00000;
            r_busy       <= 1'b0;
            r_crc_active <= 1'b0;
            r_done       <= 1'b0;
        end else if (start) begin
            // start wins from any state; a strobe in this cycle is discarded
            r_state      <= S_DATA;
            r_crc        <= CRC_INIT;
            r_cnt        <= 4'd0;
            r_busy       <= 1'b1;
            r_crc_active <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                end
                S_DATA: begin
                    if (shift_en) begin
                        r_crc <= w_next_crc;
                        if (r_cnt == CNT_DATA_LAST) begin
                            r_state      <= S_CRC;
                            r_cnt        <= 4'd0;
                            r_crc_field  <= bitrev5(~w_next_crc);
                            r_crc_active <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (shift_en) begin
                        r_crc <= {r_crc[3:0], 1'b0};
                        if (r_cnt == CNT_CRC_LAST) begin
                            r_state      <= S_DONE;
                            r_cnt        <= 4'd0;
                            r_crc_active <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Line mux: passthrough except while the inverted CRC is being shifted out.
    always_comb begin
        tx_bit_out = tx_bit_in;
        if (r_state == S_CRC) begin
            tx_bit_out = ~r_crc[4];
        end
    end

    assign crc_active = r_crc_active;
    assign busy       = r_busy;
    assign done       = r_done;
    assign crc_field  = r_crc_field;

endmodule

// File: tb/tb_usb_crc5_tx.sv
// Scoreboard bench for usb_crc5_tx: stimulus pushes expected CRC bits and
// fields, a negedge monitor pops and compares as the DUT presents them.
module tb_usb_crc5_tx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       shift_en;
    logic       tx_bit_in;
    logic       tx_bit_out;
    logic       crc_active;
    logic       busy;
    logic       done;
    logic [4:0] crc_field;

    typedef struct packed {
        logic [10:0] data;
        logic [4:0]  field;
    } fld_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_bits[$];
    fld_t exp_flds[$];
    logic obs_bits[$];
    logic       mon_b;
    fld_t       mon_e;
    logic [4:0] mon_f;

    usb_crc5_tx #(.DATA_BITS(11)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .shift_en  (shift_en),
        .tx_bit_in (tx_bit_in),
        .tx_bit_out(tx_bit_out),
        .crc_active(crc_active),
        .busy      (busy),
        .done      (done),
        .crc_field (crc_field)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Serial receive-side checker: feed data then transmitted CRC bits.
    function automatic logic [4:0] rx_residual(input logic [10:0] d, input logic [4:0] f);
        logic [4:0] c;
        logic       b;
        c = 5'b11111;
        for (int i = 0; i < 16; i++) begin
            b = (i < 11) ? d[i] : f[i-11];
            if (c[4] ^ b) c = {c[3:0], 1'b0} ^ 5'b00101;
            else          c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    // Expected field: the unique 5-bit pattern that makes the receiver see 01100.
    function automatic logic [4:0] find_field(input logic [10:0] d);
        for (int f = 0; f < 32; f++) begin
            if (rx_residual(d, 5'(f)) == 5'b01100) return 5'(f);
        end
        return 5'b00000;
    endfunction

    // Monitor: compare every consumed CRC bit and every done pulse.
    always @(negedge clk) begin
        if (!n_rst) begin
            obs_bits.delete();
        end else begin
            if (crc_active && shift_en) begin
                obs_bits.push_back(tx_bit_out);
                if (exp_bits.size() == 0) begin
                    check("unexpected_crc_bit", 32'd1, 32'd0);
                end else begin
                    mon_b = exp_bits.pop_front();
                    check("crc_bit", 32'(tx_bit_out), 32'(mon_b));
                end
            end
            if (done) begin
                if (exp_flds.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_flds.pop_front();
                    mon_f = 5'b00000;
                    for (int i = 0; i < obs_bits.size() && i < 5; i++) mon_f[i] = obs_bits[i];
                    check("crc_field", 32'(crc_field), 32'(mon_e.field));
                    check("crc_strobes", 32'(obs_bits.size()), 32'd5);
                    check("residual", 32'(rx_residual(mon_e.data, mon_f)), 32'(5'b01100));
                end
                obs_bits.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b, input int gap_max);
        tx_bit_in = b;
        shift_en  = 1'b1;
        tick();
        shift_en  = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
    endtask

    task automatic begin_field(input logic se_with_start);
        start     = 1'b1;
        shift_en  = se_with_start;
        tx_bit_in = 1'b1;
        tick();
        start     = 1'b0;
        shift_en  = 1'b0;
    endtask

    task automatic push_exp(input logic [10:0] d, input logic [4:0] f);
        fld_t e;
        e.data  = d;
        e.field = f;
        exp_flds.push_back(e);
        for (int i = 0; i < 5; i++) exp_bits.push_back(f[i]);
    endtask

    task automatic send_data(input logic [10:0] d, input int gap_max);
        for (int i = 0; i < 11; i++) strobe(d[i], gap_max);
    endtask

    task automatic send_crc(input int n, input int gap_max);
        for (int i = 0; i < n; i++) strobe(1'($urandom_range(0, 1)), gap_max);
    endtask

    task automatic run_field(input logic [10:0] d, input logic [4:0] f,
                             input int gap_max, input logic se_with_start);
        push_exp(d, f);
        begin_field(se_with_start);
        send_data(d, gap_max);
        send_crc(5, gap_max);
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] d;
        n_rst     = 1'b0;
        start     = 1'b0;
        shift_en  = 1'b0;
        tx_bit_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_crc_active", 32'(crc_active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_crc_field", 32'(crc_field), 32'd0);
        check("rst_passthru", 32'(tx_bit_out), 32'd1);
        n_rst = 1'b1;
        tick();

        // hand-computed fields: all zeros -> 00010, all ones -> 01000
        run_field(11'h000, 5'b00010, 0, 1'b0);
        run_field(11'h7FF, 5'b01000, 0, 1'b0);

        // irregular strobes give the same result as back-to-back
        run_field(11'h5A3, find_field(11'h5A3), 0, 1'b0);
        run_field(11'h5A3, find_field(11'h5A3), 7, 1'b0);
        run_field(11'h000, 5'b00010, 7, 1'b0);

        // restart after 6 data bits; the restarting start carries a strobe
        begin_field(1'b0);
        for (int i = 0; i < 6; i++) strobe(1'b1, 0);
        check("busy_mid_data", 32'(busy), 32'd1);
        push_exp(11'h000, 5'b00010);
        begin_field(1'b1);
        send_data(11'h000, 0);
        send_crc(5, 0);
        tick();
        tick();

        // asynchronous reset after two CRC bits
        push_exp(11'h000, 5'b00010);
        begin_field(1'b0);
        send_data(11'h000, 0);
        send_crc(2, 0);
        check("crc_active_mid_crc", 32'(crc_active), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_crc_active", 32'(crc_active), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_crc_field", 32'(crc_field), 32'd0);
        check("arst_bits_left", 32'(exp_bits.size()), 32'd3);
        check("arst_fields_left", 32'(exp_flds.size()), 32'd1);
        exp_bits.delete();
        exp_flds.delete();
        tick();
        n_rst = 1'b1;
        tick();
        run_field(11'h000, 5'b00010, 0, 1'b0);

        // idle: strobes ignored, pure passthrough
        for (int i = 0; i < 20; i++) begin
            tx_bit_in = 1'($urandom_range(0, 1));
            shift_en  = 1'(i % 2);
            #1;
            check("idle_passthru", 32'(tx_bit_out), 32'(tx_bit_in));
            check("idle_busy", 32'(busy), 32'd0);
            tick();
        end
        shift_en = 1'b0;

        // random fields checked against the receive residual
        for (int n = 0; n < 200; n++) begin
            d = 11'($urandom_range(0, 2047));
            run_field(d, find_field(d), 2, 1'b0);
        end

        repeat (3) tick();
        check("bits_drained", 32'(exp_bits.size()), 32'd0);
        check("fields_drained", 32'(exp_flds.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_crc5_tx.md
# usb_crc5_tx

Bit-serial USB token CRC5 generator for the transmit path. It sits between the token/SOF field shifter and the bit-stuffer/NRZI encoder. It passes the 11 data bits through while accumulating CRC5, then drives the 5 inverted CRC bits onto the line. It is the transmit counterpart of the receive-side CRC5 check and produces fields that check to residual 5'b01100.

## Interface
Parameters:
- DATA_BITS, 11, number of data bits covered by the CRC (token addr+endp or SOF frame number).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a new field and initialises the CRC.
- shift_en  in  1  bit-time strobe from the TX bit timer. Deasserted during stuffed bits and stalls.
- tx_bit_in  in  1  current data bit from the field shifter, LSB first.
- tx_bit_out  out  1  bit to the stuffer: the data bit during the data phase, the CRC bit during the CRC phase.
- crc_active  out  1  high while CRC bits are driven. The upstream shifter must hold while this is high.
- busy  out  1  high in DATA, CRC and DONE.
- done  out  1  one-cycle pulse after the last CRC bit is consumed.
- crc_field  out  5  final transmitted CRC field, bit 0 sent first. Held until the next start.

## Operation
- Polynomial x^5+x^2+1, CRC register crc[4:0], initial value 5'b11111.
- Data update on each accepted bit: fb = crc[4] ^ tx_bit_in; crc <= {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b00000).
- FSM states are IDLE, DATA, CRC and DONE.
- IDLE: tx_bit_out = tx_bit_in (passthrough), crc_active = 0, shift_en is ignored. start: crc <= 5'b11111, bit counter <= 0, go to DATA.
- DATA: tx_bit_out = tx_bit_in, combinational.
  - Each shift_en applies the CRC update and increments the counter.
  - On the shift_en where counter == DATA_BITS-1: go to CRC, clear the counter, and load crc_field <= bit-reverse(~next_crc), so crc_field[0] = ~next_crc[4].
- CRC: tx_bit_out = ~crc[4], crc_active = 1.
  - Each shift_en: crc <= {crc[3:0],1'b0}, counter++.
  - On the shift_en where counter == 4: go to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE. crc_active = 0.
- The 5 transmitted bits, in order, equal crc_field[0]..crc_field[4].
- Counter is 4 bits wide, sized for max(DATA_BITS,5). Counting is only in DATA and CRC.

## Timing
- Reset values: state IDLE, crc 5'b11111, counter 0, crc_field 5'b00000, done 0, busy 0, crc_active 0. tx_bit_out follows tx_bit_in.
- start is registered, so DATA is entered the cycle after start. A shift_en in the same cycle as start is ignored.
- Latency from the last CRC shift_en to done is 1 cycle. busy deasserts the cycle after done.
- Gaps in shift_en of any length freeze the state, crc and counter. tx_bit_out keeps driving the current bit.
- start in DATA, CRC or DONE aborts the current field and restarts as from IDLE. start has priority over shift_en and over the DONE→IDLE transition.
- n_rst asserted mid-field returns everything to reset values immediately and asynchronously. No done pulse is produced.
- crc_field updates only on the DATA→CRC transition. It is not cleared by start.

## Test plan
- All-zero field, DATA_BITS=11: 11 shift_en with tx_bit_in=0 → tx_bit_out during CRC = 0,1,0,0,0; crc_field = 5'b00010 (matches SOF frame 0, byte 0x10); done pulses one cycle after the 5th CRC strobe.
- Residual check: 200 random 11-bit fields → a serial model checker fed data+CRC (init 11111) ends at 5'b01100 every time; crc_active high for exactly 5 strobes.
- Irregular shift_en (random 0–7 idle cycles between strobes, including during CRC) → same output sequence and crc_field as back-to-back strobes for the same data.
- Restart: start after 6 data bits, then a full all-zero field → output 0,1,0,0,0; no done for the aborted field; start+shift_en in the same cycle does not count a bit.
- Reset mid-CRC, after 2 CRC bits: assert n_rst → busy=0, crc_active=0, done=0, crc_field=0; the following all-zero field → crc_field 5'b00010.
- Idle behaviour: shift_en toggling in IDLE with tx_bit_in random → tx_bit_out == tx_bit_in, busy stays 0, no state change.
